// File: rtl/ft232h_bridge_pkg.sv
// ft232h_bridge_pkg: shared state/direction types and byte width for the FT232H sync bridge
package ft232h_bridge_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, TX, RX_OE, RX_RD} state_t;
    typedef enum logic {DIR_TX, DIR_RX} dir_t;
endpackage

// File: rtl/ft232h_sync_bridge.sv
// ft232h_sync_bridge: FWFT FIFO pair <-> FT232H 245-sync bus bridge; FT232H_BRIDGE_STATS_EN adds byte counters
module ft232h_sync_bridge
    import ft232h_bridge_pkg::*;
#(
    parameter int BURST_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty,
    output logic              rd_en,
    input  logic [BYTE_W-1:0] dout,
    input  logic              full,
    output logic              wr_en,
    output logic [BYTE_W-1:0] din,
    input  logic              txe_n,
    output logic              wr_n,
    input  logic              rxf_n,
    output logic              oe_n,
    output logic              rd_n,
    inout  wire  [BYTE_W-1:0] adbus
`ifdef FT232H_BRIDGE_STATS_EN
    ,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
`endif
);
    localparam logic [7:0] LAST = 8'(BURST_MAX - 1);

    state_t     state_q;
    dir_t       last_dir_q;
    logic [7:0] cnt_q;
    logic       tx_req;
    logic       rx_req;
    logic       tx_xfer;
    logic       rx_xfer;

    assign tx_req  = ~empty & ~txe_n;
    assign rx_req  = ~rxf_n & ~full;
    assign tx_xfer = (state_q == TX) & tx_req;
    assign rx_xfer = (state_q == RX_RD) & rx_req;
    assign wr_n    = ~tx_xfer;
    assign rd_en   = tx_xfer;
    assign rd_n    = ~rx_xfer;
    assign wr_en   = rx_xfer;
    assign oe_n    = ~((state_q == RX_OE) | (state_q == RX_RD));
    assign din     = adbus;
    assign adbus   = (state_q == TX) ? dout : {BYTE_W{1'bz}};

    // Arbitration and burst control; every direction change returns through IDLE for a turnaround cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_dir_q <= DIR_RX;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_req && (!rx_req || last_dir_q == DIR_RX)) begin
                        state_q <= TX;
                        cnt_q   <= '0;
                    end else if (rx_req) begin
                        state_q <= RX_OE;
                        cnt_q   <= '0;
                    end
                end
                TX: begin
                    cnt_q <= cnt_q + 8'(tx_req);
                    if (!tx_req || cnt_q == LAST) begin
                        state_q    <= IDLE;
                        last_dir_q <= DIR_TX;
                    end
                end
                RX_OE: state_q <= RX_RD;
                RX_RD: begin
                    cnt_q <= cnt_q + 8'(rx_req);
                    if (!rx_req || cnt_q == LAST) begin
                        state_q    <= IDLE;
                        last_dir_q <= DIR_RX;
                    end
                end
            endcase
        end
    end

`ifdef FT232H_BRIDGE_STATS_EN
    logic [15:0] tx_count_q;
    logic [15:0] rx_count_q;

    // Free-running per-direction byte counters, wrapping modulo 2^16
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_q + 16'(tx_xfer);
            rx_count_q <= rx_count_q + 16'(rx_xfer);
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif
endmodule

// File: tb/tb_ft232h_sync_bridge.sv
// tb_ft232h_sync_bridge: directed bench for ft232h_sync_bridge; released bus reads 0xFF through pullups
module tb_ft232h_sync_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       empty, rd_en, full, wr_en, txe_n, wr_n, rxf_n, oe_n, rd_n;
    logic [7:0] dout, din;
    wire  [7:0] adbus;
    logic [7:0] fifo [0:15];
    logic [7:0] hmem [0:15];
    logic [7:0] ftlog [0:31];
    logic [7:0] rxlog [0:31];
    int wp = 0, rp = 0, hn = 0, hp = 0, ftn = 0, rxn = 0;

    logic       b_go = 1'b0;
    logic       empty_b, rd_en_b, wr_en_b, wr_n_b, rxf_n_b, oe_n_b, rd_n_b;
    logic [7:0] dout_b, din_b;
    wire  [7:0] adbus_b;
    int b_tp = 0, b_hp = 0;

    int n_chk = 0, n_fail = 0;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pa (adbus[g]);
        pullup pb (adbus_b[g]);
    end

    assign empty = (rp == wp);
    assign dout  = fifo[rp[3:0]];
    assign rxf_n = !(hp < hn);
    assign adbus = !oe_n ? hmem[hp[3:0]] : 8'bz;

    assign empty_b = !b_go;
    assign rxf_n_b = !b_go;
    assign dout_b  = 8'(32'h10 + b_tp);
    assign adbus_b = !oe_n_b ? 8'(32'h80 + b_hp) : 8'bz;

    always @(posedge clk) begin
        if (rd_en) rp <= rp + 1;
        if (!rd_n) hp <= hp + 1;
        if (!wr_n && !txe_n) begin
            ftlog[ftn[4:0]] <= adbus;
            ftn <= ftn + 1;
        end
        if (wr_en) begin
            rxlog[rxn[4:0]] <= din;
            rxn <= rxn + 1;
        end
        if (rd_en_b) b_tp <= b_tp + 1;
        if (!rd_n_b) b_hp <= b_hp + 1;
    end

`ifdef FT232H_BRIDGE_STATS_EN
    logic [15:0] txc, rxc, txc_b, rxc_b;
`endif

    ft232h_sync_bridge dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .rd_en(rd_en), .dout(dout),
        .full(full), .wr_en(wr_en), .din(din), .txe_n(txe_n), .wr_n(wr_n),
        .rxf_n(rxf_n), .oe_n(oe_n), .rd_n(rd_n), .adbus(adbus)
`ifdef FT232H_BRIDGE_STATS_EN
        , .tx_count(txc), .rx_count(rxc)
`endif
    );

    ft232h_sync_bridge #(.BURST_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .empty(empty_b), .rd_en(rd_en_b), .dout(dout_b),
        .full(1'b0), .wr_en(wr_en_b), .din(din_b), .txe_n(1'b0), .wr_n(wr_n_b),
        .rxf_n(rxf_n_b), .oe_n(oe_n_b), .rd_n(rd_n_b), .adbus(adbus_b)
`ifdef FT232H_BRIDGE_STATS_EN
        , .tx_count(txc_b), .rx_count(rxc_b)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fifo[wp[3:0]] = v;
        wp++;
    endtask

    initial begin
        txe_n = 1'b1;
        full  = 1'b0;
        tick();
        tick();
        chk("rst_wr_n", 16'(wr_n), 16'h1);
        chk("rst_oe_n", 16'(oe_n), 16'h1);
        chk("rst_rd_n", 16'(rd_n), 16'h1);
        chk("rst_rd_en", 16'(rd_en), 16'h0);
        chk("rst_wr_en", 16'(wr_en), 16'h0);
        chk("rst_adbus_z", 16'(adbus), 16'hff);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        txe_n = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("tx_wr_n", 16'(wr_n), 16'h0);
            chk("tx_rd_en", 16'(rd_en), 16'h1);
            chk("tx_adbus", 16'(adbus), 16'(i));
            tick();
        end
        chk("tx_drain_wr_n", 16'(wr_n), 16'h1);
        tick();
        chk("tx_idle_wr_n", 16'(wr_n), 16'h1);
        chk("tx_idle_adbus_z", 16'(adbus), 16'hff);
        chk("tx_count", 16'(ftn), 16'd8);
        chk("tx_last_byte", 16'(ftlog[7]), 16'h07);
        for (int i = 0; i < 6; i++) push(8'(i));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_pre_adbus", 16'(adbus), 16'(i));
            tick();
        end
        txe_n = 1'b1;
        #1;
        chk("stall_wr_n", 16'(wr_n), 16'h1);
        chk("stall_rd_en", 16'(rd_en), 16'h0);
        tick();
        tick();
        chk("stall_hold_wr_n", 16'(wr_n), 16'h1);
        txe_n = 1'b0;
        tick();
        for (int i = 3; i < 6; i++) begin
            chk("stall_post_wr_n", 16'(wr_n), 16'h0);
            chk("stall_post_adbus", 16'(adbus), 16'(i));
            tick();
        end
        tick();
        chk("stall_count", 16'(ftn), 16'd14);
        chk("stall_byte2", 16'(ftlog[10]), 16'h02);
        chk("stall_byte3", 16'(ftlog[11]), 16'h03);
        txe_n = 1'b1;
        hmem[0] = 8'hA5;
        hmem[1] = 8'h5A;
        hmem[2] = 8'h3C;
        hn = 3;
        tick();
        chk("rx_oe_oe_n", 16'(oe_n), 16'h0);
        chk("rx_oe_rd_n", 16'(rd_n), 16'h1);
        chk("rx_oe_wr_en", 16'(wr_en), 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rx_rd_n", 16'(rd_n), 16'h0);
            chk("rx_wr_en", 16'(wr_en), 16'h1);
            chk("rx_din", 16'(din), 16'(hmem[i]));
            tick();
        end
        chk("rx_drain_rd_n", 16'(rd_n), 16'h1);
        tick();
        chk("rx_idle_oe_n", 16'(oe_n), 16'h1);
        chk("rx_idle_adbus_z", 16'(adbus), 16'hff);
        chk("rx_count", 16'(rxn), 16'd3);
        chk("rx_first", 16'(rxlog[0]), 16'hA5);
        chk("rx_last", 16'(rxlog[2]), 16'h3C);
        full = 1'b1;
        hmem[3] = 8'h11;
        hmem[4] = 8'h22;
        hn = 5;
        tick();
        chk("bp_oe_n", 16'(oe_n), 16'h1);
        chk("bp_rd_n", 16'(rd_n), 16'h1);
        chk("bp_wr_en", 16'(wr_en), 16'h0);
        full = 1'b0;
        tick();
        tick();
        chk("bp_first_rd_n", 16'(rd_n), 16'h0);
        chk("bp_first_din", 16'(din), 16'h11);
        tick();
        full = 1'b1;
        #1;
        chk("bp_mid_rd_n", 16'(rd_n), 16'h1);
        chk("bp_mid_wr_en", 16'(wr_en), 16'h0);
        tick();
        full = 1'b0;
        tick();
        tick();
        chk("bp_resume_wr_en", 16'(wr_en), 16'h1);
        chk("bp_resume_din", 16'(din), 16'h22);
        tick();
        tick();
        chk("bp_count", 16'(rxn), 16'd5);
        chk("bp_byte3", 16'(rxlog[3]), 16'h11);
        chk("bp_byte4", 16'(rxlog[4]), 16'h22);
        chk("bp_host_ptr", 16'(hp), 16'd5);
        b_go = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("arb_tx_wr_n", 16'(wr_n_b), 16'h0);
            chk("arb_tx_oe_n", 16'(oe_n_b), 16'h1);
            chk("arb_tx_adbus", 16'(adbus_b), 16'(8'h10 + i));
            tick();
        end
        chk("arb_turn_wr_n", 16'(wr_n_b), 16'h1);
        chk("arb_turn_oe_n", 16'(oe_n_b), 16'h1);
        chk("arb_turn_adbus_z", 16'(adbus_b), 16'hff);
        tick();
        chk("arb_rxoe_oe_n", 16'(oe_n_b), 16'h0);
        chk("arb_rxoe_rd_n", 16'(rd_n_b), 16'h1);
        chk("arb_rxoe_wr_n", 16'(wr_n_b), 16'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("arb_rx_rd_n", 16'(rd_n_b), 16'h0);
            chk("arb_rx_wr_n", 16'(wr_n_b), 16'h1);
            chk("arb_rx_din", 16'(din_b), 16'(8'h80 + i));
            tick();
        end
        chk("arb_turn2_oe_n", 16'(oe_n_b), 16'h1);
        chk("arb_turn2_rd_n", 16'(rd_n_b), 16'h1);
        chk("arb_turn2_adbus_z", 16'(adbus_b), 16'hff);
        tick();
        chk("arb_alt_wr_n", 16'(wr_n_b), 16'h0);
        chk("arb_alt_adbus", 16'(adbus_b), 16'h14);
        b_go = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/ft232h_sync_bridge.md
FT232H_SYNC_BRIDGE -- requirements
Module: ft232h_sync_bridge

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-002 Parameter BURST_MAX, default 64, max bytes moved in one direction before re-arbitration (range 1..255).
REQ-003 clk  input  1  system clock, equal to the FT232H 60 MHz CLKOUT.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 empty  input  1  TX FIFO empty; first-word-fall-through, so dout is valid whenever empty=0.
REQ-006 rd_en  output  1  TX FIFO pop strobe.
REQ-007 dout  input  8  TX FIFO head byte, to host.
REQ-008 full  input  1  RX FIFO full.
REQ-009 wr_en  output  1  RX FIFO push strobe.
REQ-010 din  output  8  byte from host into RX FIFO.
REQ-011 txe_n  input  1  FT232H can accept data, active low.
REQ-012 wr_n  output  1  FT232H write strobe, active low.
REQ-013 rxf_n  input  1  FT232H has data, active low.
REQ-014 oe_n  output  1  FT232H output enable, active low.
REQ-015 rd_n  output  1  FT232H read strobe, active low.
REQ-016 adbus  inout  8  bidirectional data bus.

Function
REQ-017 FSM states: IDLE, TX, RX_OE, RX_RD; state, burst counter and last_dir are registered.
REQ-018 IDLE transitions:
- tx_req = ~empty & ~txe_n; rx_req = ~rxf_n & ~full.
- Only one request -> TX or RX_OE.
- Both -> direction opposite last_dir.
- Neither -> stay in IDLE.
REQ-019 TX: wr_n = rd_en inverse = ~(tx_req); a byte transfers on each edge where both are active.
REQ-020 TX: adbus = dout.
REQ-021 TX exit -> IDLE when tx_req=0, or after the BURST_MAX-th transfer completes; last_dir := TX.
REQ-022 RX_OE: oe_n=0, rd_n=1, adbus high-Z; lasts exactly one cycle, then RX_RD.
REQ-023 RX_RD: oe_n=0; rd_n = ~wr_en = ~(rx_req); din = adbus combinationally.
REQ-024 RX_RD exit -> IDLE when rx_req=0, or after BURST_MAX transfers; last_dir := RX.
REQ-025 adbus is driven only in TX.
REQ-026 oe_n is low only in RX_OE and RX_RD; the bridge never drives adbus while oe_n=0.
REQ-027 Every direction change passes through IDLE, giving a turnaround cycle of at least one clock.
REQ-028 Burst counter is 8-bit, clears on entry to TX/RX_OE and increments per transferred byte; no wrap occurs because exit happens at BURST_MAX.
REQ-029 txe_n/rxf_n/empty/full deasserting mid-burst stalls the strobe that same cycle with no lost or duplicated byte.

Reset
REQ-030 On rst_n=0 at an edge the FSM enters IDLE, counters clear and last_dir := RX, so TX wins the first tie.
REQ-031 Reset outputs: wr_n=1, oe_n=1, rd_n=1, rd_en=0, wr_en=0, adbus high-Z.
REQ-032 Reset asserted mid-burst aborts the burst; the bus is released after that edge.

Configuration
REQ-033 Macro FT232H_BRIDGE_STATS_EN, when defined, adds outputs tx_count[15:0] and rx_count[15:0].
REQ-034 The counters increment per transferred byte, wrap modulo 2^16 and reset to 0.
REQ-035 Without FT232H_BRIDGE_STATS_EN these ports and the counter logic are absent.

Structure
REQ-036 Package ft232h_bridge_pkg holds the state enum, the direction enum (DIR_TX/DIR_RX) and the byte-width constant.
REQ-037 Single module; the tristate adbus driver stays inline and no sub-module is required.

Verification
REQ-038 Reset: rst_n low 2 clocks -> wr_n=oe_n=rd_n=1, rd_en=wr_en=0, adbus=Z.
REQ-039 TX burst: FIFO holds 0x00..0x07, txe_n=0, rxf_n=1 -> wr_n low 8 consecutive cycles, adbus 0x00..0x07, 8 rd_en pulses, then IDLE.
REQ-040 TX stall: txe_n high after byte 0x02 -> wr_n=1 and rd_en=0 in that cycle; on return, transfers resume with 0x03 and no duplicate.
REQ-041 RX burst: rxf_n=0, host bytes 0xA5,0x5A,0x3C, full=0 -> oe_n low 1 cycle before rd_n; rd_n low 3 cycles; wr_en with din 0xA5,0x5A,0x3C.
REQ-042 RX backpressure: full=1 with rxf_n=0 -> rd_n=1, wr_en=0, no byte lost when full drops.
REQ-043 Arbitration: both sides pending, BURST_MAX=4 -> 4 TX bytes, then an IDLE cycle with adbus=Z, then an RX_OE cycle, then 4 RX bytes, alternating; bus never driven while oe_n=0.
